pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 48 ++++
 rtl/load_use_detect.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// parameter defaults and the control-output bundle with its canned values.
package pipe_ctrl_pkg;

  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int CNT_W_DEF        = 16;
  localparam int FLUSH_CNT_W      = 3;   // holds FLUSH_CYCLES-1 for 1..7

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_MEMWAIT = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic stall1;
    logic stall2;
    logic branch;
  } ctrl_t;

  function automatic ctrl_t ctrl_normal();
    ctrl_t c;
    c            = '0;
    c.pc_write   = 1'b1;
    c.ifid_write = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_memwait();
    ctrl_t c;
    c        = '0;
    c.stall2 = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_redirect();
    ctrl_t c;
    c            = ctrl_normal();
    c.ifid_flush = 1'b1;
    c.branch     = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination feeds a source actually read in ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  output logic             hazard
);

  // x0 is hardwired to zero, so a load into it never creates a dependency.
  assign hazard = ex_mem_read && (ex_rd != '0) &&
                  ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                   (id_uses_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flush bubbles and
// data-memory wait freezes, with a saturating stall performance counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int REG_W        = 5,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             jump_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             stall1,
  output logic             stall2,
  output logic             branch,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  state_e                 state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic                   hazard;
  logic                   mem_wait;
  logic                   redirect;
  ctrl_t                  ctrl;

  load_use_detect #(.REG_W(REG_W)) u_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .hazard      (hazard)
  );

  assign mem_wait = dmem_req && !dmem_ready;
  assign redirect = branch_taken || jump_taken;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    ctrl        = ctrl_normal();
    unique case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          ctrl    = ctrl_memwait();
          state_d = ST_MEMWAIT;
        end else if (redirect) begin
          ctrl        = ctrl_redirect();
          flush_cnt_d = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
          state_d     = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
        end else if (hazard) begin
          ctrl        = '0;
          ctrl.stall1 = 1'b1;
          state_d     = ST_LDSTALL;
        end
      end
      ST_LDSTALL: begin
        if (mem_wait) begin
          ctrl    = ctrl_memwait();
          state_d = ST_MEMWAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // A memory wait freezes the pipe and drops the rest of the bubbles.
        if (mem_wait) begin
          ctrl        = ctrl_memwait();
          flush_cnt_d = '0;
          state_d     = ST_MEMWAIT;
        end else begin
          ctrl        = ctrl_redirect();
          flush_cnt_d = flush_cnt_q - 1'b1;
          if (flush_cnt_q == FLUSH_CNT_W'(1)) state_d = ST_RUN;
        end
      end
      ST_MEMWAIT: begin
        if (!dmem_ready) ctrl = ctrl_memwait();
        else             state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    // Outputs are combinational, so reset must quiet them directly.
    if (reset) ctrl = '0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((ctrl.stall1 || ctrl.stall2) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign stall1      = ctrl.stall1;
  assign stall2      = ctrl.stall2;
  assign branch      = ctrl.branch;
  assign state       = state_q;
  assign stall_count = stall_cnt_q;

endmodule
